// File: rtl/tc_clk_gate_latch.sv
// -----------------------------------------------------------------------------
// tc_clk_gate_latch
//   Enable latch for the clock-gating cell. It is transparent while clk_int is
//   low and opaque while clk_int is high. An asynchronous active-low reset
//   clears it and holds it cleared for as long as reset stays asserted.
//
// Ports
//   clk_int  in   Clock whose low phase opens the latch
//   rst_ni   in   Asynchronous active-low clear
//   d        in   Enable to capture (already OR-ed with test override)
//   q        out  Latched enable, stable for the whole clk_int high phase
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module tc_clk_gate_latch (
    input  logic clk_int,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    // NOTE: this is an intentional level-sensitive latch; always_latch states
    // that intent so the storage is not mistaken for an accidental inference.
    // Reset has priority so a clear during the high phase takes effect at once.
    always_latch begin
        if (!rst_ni) begin
            q <= 1'b0;
        end else if (!clk_int) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tc_clk_gate.sv
// -----------------------------------------------------------------------------
// tc_clk_gate
//   Glitch-free integrated clock gate (latch + AND). The enable is captured
//   while clk_int is low, so any enable change during the high phase cannot
//   shorten or create a pulse on clk_o. clk_o may feed clk_int of another
//   instance to build a hierarchical gate.
//
// Ports
//   clk_int    in   Clock to be gated
//   rst_ni     in   Asynchronous active-low reset; forces clk_o low at once
//   en_i       in   Functional enable, sampled while clk_int is low
//   test_en_i  in   Test-mode override, sampled like en_i
//   clk_o      out  Gated clock
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module tc_clk_gate (
    input  logic clk_int,
    input  logic rst_ni,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_any;
    logic en_latched;

    // Either enable alone passes the clock.
    assign en_any = en_i | test_en_i;

    tc_clk_gate_latch u_latch (
        .clk_int (clk_int),
        .rst_ni  (rst_ni),
        .d       (en_any),
        .q       (en_latched)
    );

    // The latch is opaque whenever clk_int is high, so this AND only ever
    // passes complete high phases; no X-masking on purpose.
    assign clk_o = clk_int & en_latched;

endmodule

// File: tb/tb_tc_clk_gate.sv
// -----------------------------------------------------------------------------
// tb_tc_clk_gate
//   Self-checking bench for tc_clk_gate. A second instance is cascaded on the
//   first one's clk_o. The reference model decides, for every clk_int high
//   phase, whether a full pulse is expected from the enables and reset seen at
//   the rising edge; monitors check phase levels, pulse alignment and width.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_tc_clk_gate;

    logic clk_int;
    logic rst_ni;
    logic en_i, test_en_i;
    logic en2, test_en2;
    logic clk_o, clk_o2;

    int n_checks = 0;
    int n_fail   = 0;

    tc_clk_gate dut (
        .clk_int   (clk_int),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

    tc_clk_gate dut_inner (
        .clk_int   (clk_o),
        .rst_ni    (rst_ni),
        .en_i      (en2),
        .test_en_i (test_en2),
        .clk_o     (clk_o2)
    );

    initial clk_int = 1'b0;
    always #5 clk_int = ~clk_int;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A high phase carries a pulse iff reset was released and some enable was
    // set at its rising edge; the cascaded gate additionally needs the outer
    // pulse. Reset asserted mid-phase kills the rest of that phase.
    logic exp_gate  = 1'b0;
    logic exp_gate2 = 1'b0;
    int   n_exp_pulses = 0;
    int   n_got_pulses = 0;

    always @(posedge clk_int) begin
        exp_gate  = rst_ni && (en_i || test_en_i);
        exp_gate2 = exp_gate && (en2 || test_en2);
        if (exp_gate) n_exp_pulses++;
    end

    always @(negedge rst_ni) begin
        exp_gate  = 1'b0;
        exp_gate2 = 1'b0;
    end

    // Mid-phase level checks.
    always @(posedge clk_int) begin
        #2.5;
        check("high_phase_clk_o",  {31'd0, clk_o},  {31'd0, exp_gate});
        check("high_phase_clk_o2", {31'd0, clk_o2}, {31'd0, exp_gate2});
    end

    always @(negedge clk_int) begin
        #2.5;
        check("low_phase_clk_o",  {31'd0, clk_o},  32'd0);
        check("low_phase_clk_o2", {31'd0, clk_o2}, 32'd0);
    end

    // Pulse shape checks, in units of 100 ps. clk_int rises at 5 ns + k*10 ns.
    int t_rise = 0;

    always @(posedge clk_o) begin
        t_rise = int'($realtime * 10.0);
        n_got_pulses++;
        check("rise_aligned", t_rise % 100, 32'd50);
    end

    always @(negedge clk_o) begin
        if (rst_ni) check("pulse_width", int'($realtime * 10.0) - t_rise, 32'd50);
    end

    // Outside the window right after clk_int rises (where the same-timestep
    // ordering of clk_int and clk_o is undefined), clk_o must never be high
    // while clk_int is low.
    always @(clk_o or clk_int) begin
        #0.1;
        if (clk_o === 1'b1) check("clk_o_only_in_high", {31'd0, clk_int}, 32'd1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic at_high(input real off);
        @(posedge clk_int);
        #off;
    endtask

    task automatic at_low(input real off);
        @(negedge clk_int);
        #off;
    endtask

    initial begin
        rst_ni    = 1'b0;
        en_i      = 1'b0;
        test_en_i = 1'b0;
        en2       = 1'b1;
        test_en2  = 1'b0;

        #2;
        check("reset_clk_o", {31'd0, clk_o}, 32'd0);
        #10 rst_ni = 1'b1;                 // t=12, low phase

        // 1: enabled clock passes, then gated from the next phase.
        en_i = 1'b1;
        repeat (3) at_high(2.5);
        check("t1_pass", {31'd0, clk_o}, 32'd1);
        at_low(2);
        en_i = 1'b0;
        at_high(2.5);
        check("t1_gated", {31'd0, clk_o}, 32'd0);

        // 2: enable rising mid-high has no effect until next phase;
        //    falling mid-high leaves the current pulse intact.
        at_high(2);
        en_i = 1'b1;
        #0.5;
        check("t2_late_en_ignored", {31'd0, clk_o}, 32'd0);
        at_high(2.5);
        check("t2_next_phase", {31'd0, clk_o}, 32'd1);
        at_high(1);
        en_i = 1'b0;
        #2;
        check("t2_pulse_holds", {31'd0, clk_o}, 32'd1);
        at_high(2.5);
        check("t2_then_gated", {31'd0, clk_o}, 32'd0);

        // 3: test override passes the clock; removal gates from next phase.
        at_low(2);
        test_en_i = 1'b1;
        repeat (2) at_high(2.5);
        check("t3_test_pass", {31'd0, clk_o}, 32'd1);
        at_low(2);
        test_en_i = 1'b0;
        at_high(2.5);
        check("t3_test_off", {31'd0, clk_o}, 32'd0);

        // 4: reset mid-high kills the pulse at once and overrides test mode.
        at_low(2);
        en_i = 1'b1;
        at_high(1);
        check("t4_before_reset", {31'd0, clk_o}, 32'd1);
        rst_ni = 1'b0;
        #0.1;
        check("t4_reset_immediate", {31'd0, clk_o}, 32'd0);
        test_en_i = 1'b1;
        at_high(2.5);
        check("t4_reset_test_mode", {31'd0, clk_o}, 32'd0);
        test_en_i = 1'b0;
        at_high(3);
        rst_ni = 1'b1;
        #0.5;
        check("t4_release_in_high", {31'd0, clk_o}, 32'd0);
        at_high(2.5);
        check("t4_first_pulse", {31'd0, clk_o}, 32'd1);

        // 5: cascaded gates need both enables before the same rising edge.
        at_low(2);
        en2 = 1'b0;
        at_high(2.5);
        check("t5_inner_off", {31'd0, clk_o2}, 32'd0);
        check("t5_outer_on",  {31'd0, clk_o},  32'd1);
        at_low(2);
        en2 = 1'b1;
        at_high(2.5);
        check("t5_both_on", {31'd0, clk_o2}, 32'd1);
        at_low(2);
        en_i = 1'b0;
        at_high(2.5);
        check("t5_outer_off", {31'd0, clk_o2}, 32'd0);

        // 6: random enables at random offsets in both phases.
        for (int i = 0; i < 1000; i++) begin
            at_high(real'($urandom_range(1, 4)));
            en_i      = 1'($urandom);
            test_en_i = ($urandom_range(0, 7) == 0);
            en2       = 1'($urandom);
            test_en2  = ($urandom_range(0, 7) == 0);
            at_low(real'($urandom_range(1, 4)));
            en_i      = 1'($urandom);
            test_en_i = ($urandom_range(0, 7) == 0);
            en2       = 1'($urandom);
            test_en2  = ($urandom_range(0, 7) == 0);
        end

        at_high(4);
        at_low(4);
        check("pulse_count", n_got_pulses, n_exp_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
